// File: rtl/cpu_fetch.sv
// cpu_fetch: multicycle instruction-fetch / PC stage feeding cpu_control.
// Fetches one 32-bit word per instruction, hands it to decode with a
// valid/ready handshake, waits for retire and applies the branch outcome.
// Optional feature: define FETCH_TIMEOUT_EN to enable the imem ack watchdog.
module cpu_fetch #(
   parameter logic [63:0] RESET_PC       = 64'h0,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_out,
   output logic [63:0] pc_out,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        retire,
   input  logic        br_uncond,
   input  logic        br_zero,
   input  logic        br_nonzero,
   input  logic        alu_zero,
   output logic        halted,
   output logic        fault
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_WAIT_MEM,
      S_ISSUE,
      S_EXEC,
      S_HALT,
      S_FAULT
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   logic [63:0] r_pc;
   logic [63:0] r_imem_addr;
   logic [63:0] r_pc_out;
   logic [31:0] r_inst;
   logic        r_imem_req;
   logic        r_inst_valid;
   logic        r_halted;

   logic        w_is_halt;
   logic        w_taken;
   logic        w_timeout;
   logic [63:0] w_off_b;
   logic [63:0] w_off_cb;
   logic [63:0] w_pc_next;

   // HALT is the all-ones 11-bit opcode field.
   assign w_is_halt = (imem_rdata[31:21] == 11'h7FF);

   // Branch offsets: word offsets sign-extended to 64 bits, scaled by 4.
   assign w_off_b  = {{36{r_inst[25]}}, r_inst[25:0], 2'b00};
   assign w_off_cb = {{43{r_inst[23]}}, r_inst[23:5], 2'b00};
   assign w_taken  = br_uncond | (br_zero & alu_zero) | (br_nonzero & ~alu_zero);

`ifdef FETCH_TIMEOUT_EN
   logic [31:0] r_tcnt;
   logic        r_fault;

   // An ack arriving on the limit cycle takes priority over the timeout.
   assign w_timeout = (r_state == S_WAIT_MEM) && !imem_ack &&
                      (r_tcnt == TIMEOUT_CYCLES - 32'd1);

   // Watchdog: counts WAIT_MEM cycles, held at zero in every other state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tcnt  <= '0;
         r_fault <= 1'b0;
      end else begin
         if (r_state != S_WAIT_MEM) begin
            r_tcnt <= '0;
         end else begin
            r_tcnt <= r_tcnt + 32'd1;
         end
         if (w_timeout) begin
            r_fault <= 1'b1;
         end
      end
   end

   assign fault = r_fault;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_timeout        = 1'b0;
   assign fault            = 1'b0;
`endif

   // Next PC after retire: fall-through unless the branch is taken.
   always_comb begin
      w_pc_next = r_pc_out + 64'd4;
      if (w_taken) begin
         if (br_uncond) begin
            w_pc_next = r_pc_out + w_off_b;
         end else begin
            w_pc_next = r_pc_out + w_off_cb;
         end
      end
   end

   // Next-state logic for the fetch sequencer.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FETCH: begin
            w_state_next = S_WAIT_MEM;
         end
         S_WAIT_MEM: begin
            if (imem_ack) begin
               w_state_next = w_is_halt ? S_HALT : S_ISSUE;
            end else if (w_timeout) begin
               w_state_next = S_FAULT;
            end
         end
         S_ISSUE: begin
            if (inst_ready) begin
               w_state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (retire) begin
               w_state_next = S_FETCH;
            end
         end
         default: begin
            w_state_next = r_state;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath and registered handshake outputs, updated per state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= RESET_PC;
         r_imem_addr  <= RESET_PC;
         r_imem_req   <= 1'b0;
         r_inst       <= '0;
         r_pc_out     <= '0;
         r_inst_valid <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               r_imem_req  <= 1'b1;
               r_imem_addr <= r_pc;
            end
            S_WAIT_MEM: begin
               if (imem_ack) begin
                  r_inst     <= imem_rdata;
                  r_pc_out   <= r_pc;
                  r_imem_req <= 1'b0;
                  if (w_is_halt) begin
                     r_halted <= 1'b1;
                  end else begin
                     r_inst_valid <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_imem_req <= 1'b0;
               end
            end
            S_ISSUE: begin
               if (inst_ready) begin
                  r_inst_valid <= 1'b0;
               end
            end
            S_EXEC: begin
               if (retire) begin
                  r_pc <= w_pc_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign imem_req   = r_imem_req;
   assign imem_addr  = r_imem_addr;
   assign inst_out   = r_inst;
   assign pc_out     = r_pc_out;
   assign inst_valid = r_inst_valid;
   assign halted     = r_halted;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch with an address/instruction scoreboard.
module tb_cpu_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst_out;
   logic [63:0] pc_out;
   logic        inst_valid;
   logic        inst_ready;
   logic        retire;
   logic        br_uncond;
   logic        br_zero;
   logic        br_nonzero;
   logic        alu_zero;
   logic        halted;
   logic        fault;

   always #5 clk = ~clk;

   cpu_fetch #(
      .RESET_PC      (64'h0),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_rdata(imem_rdata),
      .inst_out  (inst_out),
      .pc_out    (pc_out),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .retire    (retire),
      .br_uncond (br_uncond),
      .br_zero   (br_zero),
      .br_nonzero(br_nonzero),
      .alu_zero  (alu_zero),
      .halted    (halted),
      .fault     (fault)
   );

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned ACK_DLY = 15;
`else
   localparam int unsigned ACK_DLY = 3;
`endif

   localparam logic [31:0] ADD_W = 32'h8B020020;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] addr_q[$];
   logic [95:0] inst_q[$];
   logic [63:0] cur_pc;
   logic [31:0] cur_inst;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called on a negedge; returns on the first negedge with imem_req high.
   task automatic wait_req(input string tag, output logic [63:0] pc_exp);
      int unsigned n = 0;
      while (imem_req !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_req"}, imem_req, 64'd1);
      pc_exp = 'x;
      if (addr_q.size() > 0) pc_exp = addr_q.pop_front();
      check({tag, "_addr"}, imem_addr, pc_exp);
   endtask

   task automatic do_fetch(input string tag, input logic [31:0] word,
                           input int unsigned delay, input logic is_halt);
      logic [63:0] pc_exp;
      wait_req(tag, pc_exp);
      repeat (delay) @(negedge clk);
      check({tag, "_pre_valid"}, inst_valid, 64'd0);
      imem_ack   = 1'b1;
      imem_rdata = word;
      if (!is_halt) inst_q.push_back({pc_exp, word});
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      check({tag, "_req_drop"}, imem_req, 64'd0);
      check({tag, "_valid"}, inst_valid, {63'd0, !is_halt});
      check({tag, "_halted"}, halted, {63'd0, is_halt});
      if (!is_halt) begin
         {cur_pc, cur_inst} = inst_q.pop_front();
         check({tag, "_inst"}, inst_out, cur_inst);
         check({tag, "_pc"}, pc_out, cur_pc);
      end
   endtask

   // Decode stall with stray retire/ack pulses, then accept.
   task automatic issue(input string tag, input int unsigned stall);
      for (int unsigned i = 0; i < stall; i++) begin
         retire   = (i == 0);
         imem_ack = (i == 1);
         @(negedge clk);
         retire   = 1'b0;
         imem_ack = 1'b0;
         check({tag, "_stall_valid"}, inst_valid, 64'd1);
         check({tag, "_stall_inst"}, inst_out, cur_inst);
         check({tag, "_stall_pc"}, pc_out, cur_pc);
      end
      inst_ready = 1'b1;
      @(negedge clk);
      check({tag, "_accept"}, inst_valid, 64'd0);
      @(negedge clk);
      inst_ready = 1'b0;
      check({tag, "_ready_idle"}, inst_valid, 64'd0);
   endtask

   // One cycle of branch noise without retire, then the real retire.
   task automatic retire_op(input string tag, input logic bu, input logic bz,
                            input logic bnz, input logic az, input logic [63:0] exp_next);
      br_uncond  = 1'b1;
      br_zero    = 1'b1;
      br_nonzero = 1'b1;
      alu_zero   = ~az;
      @(negedge clk);
      check({tag, "_noretire"}, imem_req, 64'd0);
      retire     = 1'b1;
      br_uncond  = bu;
      br_zero    = bz;
      br_nonzero = bnz;
      alu_zero   = az;
      addr_q.push_back(exp_next);
      @(negedge clk);
      retire     = 1'b0;
      br_uncond  = 1'b0;
      br_zero    = 1'b0;
      br_nonzero = 1'b0;
      alu_zero   = 1'b0;
      check({tag, "_lat1"}, imem_req, 64'd0);
      @(negedge clk);
      check({tag, "_lat2"}, imem_req, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] pc_tmp;
      int unsigned seen;
      reset      = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      inst_ready = 1'b0;
      retire     = 1'b0;
      br_uncond  = 1'b0;
      br_zero    = 1'b0;
      br_nonzero = 1'b0;
      alu_zero   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req", imem_req, 64'd0);
      check("rst_valid", inst_valid, 64'd0);
      check("rst_inst", inst_out, 64'd0);
      check("rst_pc", pc_out, 64'd0);
      check("rst_halted", halted, 64'd0);
      check("rst_fault", fault, 64'd0);
      addr_q.push_back(64'h0);
      reset = 1'b0;

      // ADD at 0, ack two cycles after request, no branch.
      do_fetch("t1_add", ADD_W, 2, 1'b0);
      issue("t1", 0);
      retire_op("t1", 1'b0, 1'b0, 1'b0, 1'b0, 64'h4);

      // B +3 from 4 and from 0x10.
      do_fetch("t2_b4", 32'h14000003, 0, 1'b0);
      issue("t2a", 1);
      retire_op("t2a", 1'b1, 1'b0, 1'b0, 1'b0, 64'h10);
      do_fetch("t2_b10", 32'h14000003, 1, 1'b0);
      issue("t2b", 0);
      retire_op("t2b", 1'b1, 1'b0, 1'b0, 1'b0, 64'h1C);

      // alu_zero alone does not branch.
      do_fetch("t3_add1c", ADD_W, 0, 1'b0);
      issue("t3a", 0);
      retire_op("t3a", 1'b0, 1'b0, 1'b0, 1'b1, 64'h20);

      // CBZ -2 at 0x20: taken then not taken.
      do_fetch("t3_cbz_t", 32'hB4FFFFC0, 1, 1'b0);
      issue("t3b", 0);
      retire_op("t3b", 1'b0, 1'b1, 1'b0, 1'b1, 64'h18);
      do_fetch("t3_add18", ADD_W, 0, 1'b0);
      issue("t3c", 0);
      retire_op("t3c", 1'b0, 1'b0, 1'b0, 1'b0, 64'h1C);
      do_fetch("t3_add1c2", ADD_W, 0, 1'b0);
      issue("t3d", 0);
      retire_op("t3d", 1'b0, 1'b0, 1'b0, 1'b0, 64'h20);
      do_fetch("t3_cbz_nt", 32'hB4FFFFC0, 0, 1'b0);
      issue("t3e", 0);
      retire_op("t3e", 1'b0, 1'b1, 1'b0, 1'b0, 64'h24);

      // CBNZ +4 at 0x24 with a 5-cycle decode stall.
      do_fetch("t4_cbnz", 32'hB5000080, 0, 1'b0);
      issue("t4", 5);
      retire_op("t4", 1'b0, 1'b0, 1'b1, 1'b0, 64'h34);

      // B -14 from 0x34 reaches the top word, then +4 wraps to 0.
      do_fetch("tw_bneg", 32'h17FFFFF2, 0, 1'b0);
      issue("tw1", 0);
      retire_op("tw1", 1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
      do_fetch("tw_top", ADD_W, 0, 1'b0);
      issue("tw2", 0);
      retire_op("tw2", 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);

      // HALT: nothing moves for 20 cycles despite stray inputs.
      do_fetch("t5_halt", 32'hFFE00000, 1, 1'b1);
      seen = 0;
      for (int unsigned i = 0; i < 20; i++) begin
         retire     = 1'b1;
         imem_ack   = 1'b1;
         inst_ready = 1'b1;
         @(negedge clk);
         if (imem_req !== 1'b0 || inst_valid !== 1'b0) seen++;
      end
      retire     = 1'b0;
      imem_ack   = 1'b0;
      inst_ready = 1'b0;
      check("t5_quiet", seen, 64'd0);
      check("t5_sticky", halted, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check("t5_rst_halted", halted, 64'd0);
      @(negedge clk);
      addr_q.push_back(64'h0);
      reset = 1'b0;
      do_fetch("t5_restart", ADD_W, ACK_DLY, 1'b0);
      issue("t5", 0);
      retire_op("t5", 1'b0, 1'b0, 1'b0, 1'b0, 64'h4);

      // No ack at all from address 4.
      wait_req("t6_noack", pc_tmp);
`ifdef FETCH_TIMEOUT_EN
      repeat (15) @(negedge clk);
      check("t6_fault_pre", fault, 64'd0);
      check("t6_req_pre", imem_req, 64'd1);
      @(negedge clk);
      check("t6_fault", fault, 64'd1);
      check("t6_req_drop", imem_req, 64'd0);
      repeat (3) @(negedge clk);
      check("t6_fault_sticky", fault, 64'd1);
      check("t6_req_quiet", imem_req, 64'd0);
`else
      repeat (30) @(negedge clk);
      check("t6_nofault", fault, 64'd0);
      check("t6_req_held", imem_req, 64'd1);
`endif

      // Reset during an outstanding fetch; a late ack must be discarded.
      reset = 1'b1;
      @(negedge clk);
      check("t7_req_drop", imem_req, 64'd0);
      check("t7_fault_clr", fault, 64'd0);
      reset      = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = ADD_W;
      addr_q.push_back(64'h0);
      @(negedge clk);
      imem_ack = 1'b0;
      do_fetch("t7_after", 32'h14000001, 1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
